// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes, AluOp/ALUSrcB/PCSource codes.
// The TRAP state exists only when OVFL_TRAP_EN is defined.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT, S_ILLEGAL, S_BUSERR
`ifdef OVFL_TRAP_EN
    , S_TRAP
`endif
  } ctrlState_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ANDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;

  localparam logic [1:0] SRCB_REGB     = 2'd0;
  localparam logic [1:0] SRCB_ZEXT     = 2'd1;
  localparam logic [1:0] SRCB_SEXT     = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH1 = 2'd3;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic logic [2:0] aluOpFor(input logic [3:0] opcode);
    case (opcode)
      OP_AND, OP_ANDI: aluOpFor = ALU_AND;
      OP_OR:           aluOpFor = ALU_OR;
      OP_SUB:          aluOpFor = ALU_SUB;
      default:         aluOpFor = ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] srcBFor(input logic [3:0] opcode);
    case (opcode)
      OP_ADDI: srcBFor = SRCB_SEXT;
      OP_ANDI: srcBFor = SRCB_ZEXT;
      default: srcBFor = SRCB_REGB;
    endcase
  endfunction

  // Only the signed arithmetic ops can overflow; logical ops never trap.
  function automatic logic ovflChecked(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ADDI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MemReady-low cycles of one memory access; flags the cycle that would be the
// MEM_TIMEOUT-th wait so the FSM can abort to a bus error instead.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [7:0] waitCount;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)    waitCount <= '0;
    else if (clear)  waitCount <= '0;
    else if (enable) waitCount <= waitCount + 8'd1;
  end

  assign timeout = enable && (waitCount == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with bounded memory waits.
// Optional OVFL_TRAP_EN adds a TRAP state taken on signed overflow in execute.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       ovfl,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ALUOutWrite,
  output logic [1:0] ALUSrcB,
  output logic [2:0] AluOp,
  output logic [1:0] PCSource,
  output logic       Trap,
  output logic       BusErr,
  output logic       Halted,
  output logic       Illegal
);

  ctrlState_e state, nextState;
  logic       waitEn, timeout;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= S_RESET;
    else          state <= nextState;
  end

  assign waitEn = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !MemReady;

  // Any state change restarts the count, which covers every entry into a wait state.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) timer (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .clear   (nextState != state),
    .enable  (waitEn),
    .timeout (timeout)
  );

`ifndef OVFL_TRAP_EN
  logic unusedOvfl;
  assign unusedOvfl = ovfl;
`endif

  always_comb begin
    // NOTE: every output and nextState gets a default first so no branch of the case infers a latch.
    nextState   = state;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUOutWrite = 1'b0;
    ALUSrcB     = SRCB_REGB;
    AluOp       = ALU_AND;
    PCSource    = PC_INC;
    Trap        = 1'b0;
    BusErr      = 1'b0;
    Halted      = 1'b0;
    Illegal     = 1'b0;
    unique case (state)
      S_RESET: nextState = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady)     nextState = S_DECODE;
        else if (timeout) nextState = S_BUSERR;
      end
      S_DECODE: begin
        ALUSrcB     = SRCB_SEXT_SH1;
        AluOp       = ALU_ADD;
        ALUOutWrite = 1'b1;
        case (Opcode)
          OP_ADD, OP_AND, OP_OR, OP_SUB: nextState = S_EXEC_R;
          OP_ADDI, OP_ANDI:              nextState = S_EXEC_I;
          OP_LW, OP_SW:                  nextState = S_MEM_ADDR;
          OP_BEQ:                        nextState = S_BRANCH;
          OP_J:                          nextState = S_JUMP;
          OP_HALT:                       nextState = S_HALT;
          default:                       nextState = S_ILLEGAL;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = srcBFor(Opcode);
        AluOp       = aluOpFor(Opcode);
        ALUOutWrite = 1'b1;
        nextState   = S_WB_ALU;
`ifdef OVFL_TRAP_EN
        if (ovfl && ovflChecked(Opcode)) nextState = S_TRAP;
`endif
      end
      S_WB_ALU: begin
        RegWrite  = 1'b1;
        nextState = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_SEXT;
        AluOp       = ALU_ADD;
        ALUOutWrite = 1'b1;
        nextState   = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)     nextState = S_MEM_WB;
        else if (timeout) nextState = S_BUSERR;
      end
      S_MEM_WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        nextState = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady)     nextState = S_FETCH;
        else if (timeout) nextState = S_BUSERR;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_REGB;
        AluOp     = ALU_SUB;
        PCSource  = PC_ALUOUT;
        PCWrite   = Zero;
        nextState = S_FETCH;
      end
      S_JUMP: begin
        PCSource  = PC_JUMP;
        PCWrite   = 1'b1;
        nextState = S_FETCH;
      end
      S_HALT:    Halted  = 1'b1;
      S_ILLEGAL: Illegal = 1'b1;
      S_BUSERR:  BusErr  = 1'b1;
`ifdef OVFL_TRAP_EN
      S_TRAP: begin
        Trap      = 1'b1;
        nextState = S_FETCH;
      end
`endif
      default: nextState = S_RESET;
    endcase
  end

endmodule
